vram_arbiter: RTL and testbench

- Shares one single-port, synchronous-read framebuffer RAM between the composite video scanout fetch and the 6502 CPU bus.
- Video has fixed-latency priority; the CPU is guaranteed forward progress through a starvation limit.
- Sits between the pixel timing/pattern path (scanout side) and the CPU bus bridge; drives the RAM address, write and data pins directly.

---
 rtl/vram_arbiter.sv | 133 +++++++++++++
 tb/tb_vram_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_arbiter.sv
// Arbiter sharing one synchronous-read framebuffer RAM between video scanout and the 6502 bus.
// Video wins by default; a CPU request that keeps losing is forced through once the video holding slot is empty.
module vram_arbiter #(
   parameter int ADDR_W     = 13,
   parameter int DATA_W     = 8,
   parameter int STARVE_LIM = 6
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              vid_req,
   input  logic [ADDR_W-1:0] vid_addr,
   output logic [DATA_W-1:0] vid_data,
   output logic              vid_valid,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_ack,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_we,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata
);

   localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIM);

   typedef enum logic [1:0] {TAG_NONE, TAG_VID, TAG_CPU_RD} tag_t;
   typedef enum logic [1:0] {ST_IDLE, ST_RD, ST_ACK} cpu_state_t;

   cpu_state_t        state_q, state_d;
   logic [3:0]        starve_q;
   logic              vid_pend_q;
   logic [ADDR_W-1:0] vid_pend_addr_q;
   tag_t              tag_q [2];

   logic              cpu_elig, cpu_forced;
   logic              issue_vid, issue_cpu, pend_load;
   logic [ADDR_W-1:0] issue_addr;
   tag_t              issue_tag;

   assign cpu_elig   = (state_q == ST_IDLE) && cpu_req;
   // Forcing waits for an empty holding slot so a colliding fetch can always be parked.
   assign cpu_forced = cpu_elig && (starve_q == STARVE_MAX) && !vid_pend_q;

   // NOTE: every signal gets a default before the priority chain, so no path leaves one unassigned (no latch).
   always_comb begin
      issue_vid  = 1'b0;
      issue_cpu  = 1'b0;
      pend_load  = 1'b0;
      issue_addr = vid_addr;
      if (vid_pend_q) begin
         issue_vid  = 1'b1;
         issue_addr = vid_pend_addr_q;
         pend_load  = vid_req;
      end else if (cpu_forced) begin
         issue_cpu  = 1'b1;
         issue_addr = cpu_addr;
         pend_load  = vid_req;
      end else if (vid_req) begin
         issue_vid  = 1'b1;
      end else if (cpu_elig) begin
         issue_cpu  = 1'b1;
         issue_addr = cpu_addr;
      end
   end

   always_comb begin
      issue_tag = TAG_NONE;
      if (issue_vid)
         issue_tag = TAG_VID;
      else if (issue_cpu && !cpu_we)
         issue_tag = TAG_CPU_RD;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (issue_cpu) state_d = cpu_we ? ST_ACK : ST_RD;
         ST_RD:   if (tag_q[1] == TAG_CPU_RD) state_d = ST_ACK;
         ST_ACK:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q         <= ST_IDLE;
         starve_q        <= 4'd0;
         vid_pend_q      <= 1'b0;
         vid_pend_addr_q <= '0;
         tag_q[0]        <= TAG_NONE;
         tag_q[1]        <= TAG_NONE;
         ram_addr        <= '0;
         ram_we          <= 1'b0;
         ram_wdata       <= '0;
         vid_data        <= '0;
         vid_valid       <= 1'b0;
         cpu_ack         <= 1'b0;
         cpu_rdata       <= '0;
      end else begin
         state_q    <= state_d;
         vid_pend_q <= pend_load;
         if (pend_load)
            vid_pend_addr_q <= vid_addr;

         if (!cpu_req || issue_cpu)
            starve_q <= 4'd0;
         else if (cpu_elig && starve_q < STARVE_MAX)
            starve_q <= starve_q + 4'd1;

         ram_we <= issue_cpu && cpu_we;
         if (issue_vid || issue_cpu)
            ram_addr <= issue_addr;
         if (issue_cpu && cpu_we)
            ram_wdata <= cpu_wdata;

         // RAM samples one edge after issue; its data is captured on the edge after that.
         tag_q[0] <= issue_tag;
         tag_q[1] <= tag_q[0];

         vid_valid <= (tag_q[1] == TAG_VID);
         if (tag_q[1] == TAG_VID)
            vid_data <= ram_rdata;

         cpu_ack <= (issue_cpu && cpu_we) || (tag_q[1] == TAG_CPU_RD);
         if (tag_q[1] == TAG_CPU_RD)
            cpu_rdata <= ram_rdata;
      end
   end

endmodule

// File: tb/tb_vram_arbiter.sv
// Randomized bench for vram_arbiter against a transaction-level schedule model with a behavioural RAM.
// Each edge the model decides the issued access and books the future vid_valid/cpu_ack it implies.
module tb_vram_arbiter;

   localparam int STARVE_LIM = 6;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        vid_req = 1'b0;
   logic [12:0] vid_addr = '0;
   logic [7:0]  vid_data;
   logic        vid_valid;
   logic        cpu_req = 1'b0;
   logic        cpu_we = 1'b0;
   logic [12:0] cpu_addr = '0;
   logic [7:0]  cpu_wdata = '0;
   logic        cpu_ack;
   logic [7:0]  cpu_rdata;
   logic [12:0] ram_addr;
   logic        ram_we;
   logic [7:0]  ram_wdata;
   logic [7:0]  ram_rdata;

   vram_arbiter #(.ADDR_W(13), .DATA_W(8), .STARVE_LIM(STARVE_LIM)) dut (
      .clk(clk), .reset(reset),
      .vid_req(vid_req), .vid_addr(vid_addr), .vid_data(vid_data), .vid_valid(vid_valid),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
      .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] init_val(input logic [12:0] a);
      return (a == 13'h0040) ? 8'h5A : (a[7:0] ^ 8'hA5);
   endfunction

   // Behavioural single-port RAM, read-first, one edge of read latency.
   logic [7:0] ram_mem [8192];
   bit         ram_written [8192];
   always @(posedge clk) begin
      if (ram_we) begin
         ram_mem[ram_addr]     <= ram_wdata;
         ram_written[ram_addr] <= 1'b1;
      end
      ram_rdata <= ram_written[ram_addr] ? ram_mem[ram_addr] : init_val(ram_addr);
   end

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // Reference model state.
   logic [7:0]  mmem [8192];
   bit          m_pend;
   logic [12:0] m_pend_addr;
   int          m_starve;
   int          m_cpu_free;
   int          edge_n;
   bit          exp_vv [8];
   logic [7:0]  exp_vd [8];
   bit          exp_ack [8];
   bit          exp_rdv [8];
   logic [7:0]  exp_rd [8];
   bit          now_iss, now_we;
   logic [12:0] now_addr;
   logic [7:0]  now_wd;
   int          lat_q [$];

   bit          lat_strict = 1'b0;
   int          cpu_mode = 0;
   int          cpu_done = 0;
   int          last_ack_edge = -1;
   logic [7:0]  last_rdata;
   int          last_vv_edge = -1;
   logic [7:0]  last_vd;

   function automatic void model_clear();
      m_pend = 1'b0;
      m_starve = 0;
      m_cpu_free = 0;
      for (int i = 0; i < 8; i++) begin
         exp_vv[i] = 1'b0; exp_ack[i] = 1'b0; exp_rdv[i] = 1'b0;
      end
      lat_q.delete();
   endfunction

   // Decide the access granted at the coming edge from the priority rules and book its results.
   function automatic void model_edge();
      int k0 = edge_n % 8;
      int k2 = (edge_n + 2) % 8;
      bit elig = cpu_req && (edge_n >= m_cpu_free);
      bit iss_v = 1'b0;
      bit iss_c = 1'b0;
      logic [12:0] a = vid_addr;
      if (m_pend) begin
         iss_v = 1'b1;
         a = m_pend_addr;
         m_pend = vid_req;
         m_pend_addr = vid_addr;
      end else if (elig && m_starve == STARVE_LIM) begin
         iss_c = 1'b1;
         if (vid_req) begin
            m_pend = 1'b1;
            m_pend_addr = vid_addr;
         end
      end else if (vid_req) begin
         iss_v = 1'b1;
      end else if (elig) begin
         iss_c = 1'b1;
      end
      if (!cpu_req || iss_c) m_starve = 0;
      else if (elig && m_starve < STARVE_LIM) m_starve++;
      if (vid_req) lat_q.push_back(edge_n);
      now_iss = iss_v || iss_c;
      now_we  = iss_c && cpu_we;
      if (iss_v) begin
         now_addr   = a;
         exp_vv[k2] = 1'b1;
         exp_vd[k2] = mmem[a];
      end
      if (iss_c) begin
         now_addr = cpu_addr;
         if (cpu_we) begin
            mmem[cpu_addr] = cpu_wdata;
            now_wd       = cpu_wdata;
            exp_ack[k0]  = 1'b1;
            m_cpu_free   = edge_n + 2;
         end else begin
            exp_ack[k2] = 1'b1;
            exp_rdv[k2] = 1'b1;
            exp_rd[k2]  = mmem[cpu_addr];
            m_cpu_free  = edge_n + 4;
         end
      end
   endfunction

   task automatic new_cpu_req();
      cpu_req   = 1'b1;
      cpu_we    = 1'($urandom % 2);
      cpu_addr  = 13'($urandom % 64);
      cpu_wdata = 8'($urandom);
   endtask

   // One clock edge: model, clock, compare, then let the CPU requester react.
   task automatic tick();
      int k0 = edge_n % 8;
      model_edge();
      @(posedge clk);
      #1;
      check("vid_valid", vid_valid, exp_vv[k0]);
      if (exp_vv[k0]) check("vid_data", vid_data, exp_vd[k0]);
      check("cpu_ack", cpu_ack, exp_ack[k0]);
      if (exp_rdv[k0]) check("cpu_rdata", cpu_rdata, exp_rd[k0]);
      check("ram_we", ram_we, now_we);
      if (now_iss) check("ram_addr", ram_addr, now_addr);
      if (now_we) check("ram_wdata", ram_wdata, now_wd);
      if (vid_valid) begin
         last_vv_edge = edge_n;
         last_vd = vid_data;
         if (lat_q.size() == 0) check("vid_extra", 1, 0);
         else begin
            int l = edge_n - lat_q.pop_front();
            if (lat_strict) check("vid_lat2", l, 2);
            else check("vid_lat_2or3", (l == 2 || l == 3), 1);
         end
      end
      exp_vv[k0] = 1'b0; exp_ack[k0] = 1'b0; exp_rdv[k0] = 1'b0;
      edge_n++;
      if (cpu_ack) begin
         last_ack_edge = edge_n - 1;
         last_rdata = cpu_rdata;
         cpu_done++;
      end
      if (cpu_req && cpu_ack) begin
         if (cpu_mode == 1 && ($urandom % 2) == 1) new_cpu_req();
         else cpu_req = 1'b0;
      end else if (!cpu_req && cpu_mode == 1 && ($urandom % 3) == 0) begin
         new_cpu_req();
      end
   endtask

   task automatic idle(input int n);
      vid_req = 1'b0;
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic cpu_wait(input int budget);
      int n = 0;
      while (cpu_req && n < budget) begin
         tick();
         n++;
      end
      if (cpu_req) begin
         check("cpu_timeout", 1, 0);
         cpu_req = 1'b0;
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_vid_valid"}, vid_valid, 0);
      check({tag, "_vid_data"}, vid_data, 0);
      check({tag, "_cpu_ack"}, cpu_ack, 0);
      check({tag, "_cpu_rdata"}, cpu_rdata, 0);
      check({tag, "_ram_addr"}, ram_addr, 0);
      check({tag, "_ram_we"}, ram_we, 0);
      check({tag, "_ram_wdata"}, ram_wdata, 0);
   endtask

   initial begin
      int s, done0;
      for (int i = 0; i < 8192; i++) mmem[i] = init_val(13'(i));
      model_clear();
      edge_n = 0;
      repeat (2) @(posedge clk);
      #1;
      check_all_zero("rst");
      @(negedge clk);
      reset = 1'b0;

      // Single fetch of a known byte at edge 10.
      idle(10);
      vid_req = 1'b1; vid_addr = 13'h0040;
      tick();
      idle(4);
      check("t1_valid_edge", last_vv_edge, 12);
      check("t1_data", last_vd, 8'h5A);
      check("t1_no_ack", last_ack_edge, -1);

      // CPU write then read-back with no video.
      cpu_mode = 0;
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 13'h0100; cpu_wdata = 8'hC3;
      s = edge_n;
      cpu_wait(10);
      check("t2_wr_ack_edge", last_ack_edge, s);
      idle(1);
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h0100;
      s = edge_n;
      cpu_wait(10);
      check("t2_rd_ack_edge", last_ack_edge, s + 2);
      check("t2_rd_data", last_rdata, 8'hC3);
      idle(3);

      // Continuous video against a pending CPU read: forced after exactly STARVE_LIM losses.
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h0011;
      s = edge_n;
      for (int i = 0; i < 14; i++) begin
         vid_req = 1'b1; vid_addr = 13'($urandom);
         tick();
      end
      vid_req = 1'b0;
      cpu_wait(20);
      check("t3_forced_ack_edge", last_ack_edge, s + STARVE_LIM + 2);
      idle(4);

      // Video and CPU write collide with the counter at zero.
      vid_req = 1'b1; vid_addr = 13'h0123;
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 13'h0022; cpu_wdata = 8'h9E;
      s = edge_n;
      tick();
      vid_req = 1'b0;
      cpu_wait(10);
      check("t4_wr_ack_edge", last_ack_edge, s + 1);
      idle(3);

      // Asynchronous reset one cycle after a CPU read issue.
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h0005;
      tick();
      tick();
      #3;
      reset = 1'b1;
      #1;
      check_all_zero("arst");
      cpu_req = 1'b0;
      model_clear();
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      idle(5);
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h0005;
      s = edge_n;
      cpu_wait(10);
      check("t5_post_rst_ack_edge", last_ack_edge, s + 2);
      idle(3);

      // One 858-pixel line of alternating fetches with a CPU stream on the gaps.
      lat_strict = 1'b1;
      cpu_mode = 1;
      done0 = cpu_done;
      for (int i = 0; i < 858; i++) begin
         vid_req = (i % 2 == 0);
         vid_addr = 13'($urandom);
         tick();
      end
      cpu_mode = 0;
      vid_req = 1'b0;
      cpu_wait(20);
      idle(4);
      lat_strict = 1'b0;
      check("t6_cpu_progress", (cpu_done - done0) > 100, 1);

      // Random mix with heavy video load.
      cpu_mode = 1;
      for (int i = 0; i < 3000; i++) begin
         vid_req = (($urandom % 4) != 0);
         vid_addr = 13'($urandom);
         tick();
      end
      cpu_mode = 0;
      vid_req = 1'b0;
      cpu_wait(100);
      idle(5);
      check("vid_no_drop", lat_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
